// File: rtl/delta_collect.sv
// Receive-side endpoint of the delta lane-adder pipeline: grants issue credits,
// captures every result beat into a FIFO and re-presents it on valid/ready.
module delta_collect #(
  parameter int DW     = 16,
  parameter int H_TILE = 1,
  parameter int DEPTH  = 16,
  parameter int A_LAT  = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      credit_ok_o,
  input  logic                      issue_i,
  input  logic                      in_valid_i,
  input  logic [H_TILE*DW-1:0]      in_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [H_TILE*DW-1:0]      out_data_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [$clog2(DEPTH):0]    inflight_o,
  output logic [2:0]                err_o
);

  localparam int W  = H_TILE * DW;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Pointers wrap naturally only for a power-of-2 depth; a shallower FIFO than
  // the pipeline latency could not absorb a full burst of issued beats.
  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < A_LAT + 1) begin : g_param_check
    $error("delta_collect: DEPTH must be a power of 2 and >= A_LAT+1");
  end

  logic [CW-1:0] credits_q, credits_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]    err_q;
  logic          credit_ok_q;
  logic [W-1:0]  mem_q [DEPTH];

  logic pop, spurious, push_acc, drop_full, issue_no_credit;

  assign out_valid_o     = (count_q != '0);
  assign pop             = out_valid_o & out_ready_i;
  assign spurious        = in_valid_i & (inflight_q == '0);
  assign push_acc        = in_valid_i & ~spurious & ((count_q != FULL) | pop);
  assign drop_full       = in_valid_i & ~spurious & ~push_acc;
  assign issue_no_credit = issue_i & ~credit_ok_q;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    credits_d = credits_q;
    if (issue_i && credits_q != '0) credits_d = credits_d - 1'b1;
    if (pop && credits_d != FULL)   credits_d = credits_d + 1'b1;

    inflight_d = inflight_q;
    if (in_valid_i && inflight_q != '0) inflight_d = inflight_d - 1'b1;
    if (issue_i && inflight_d != '1)    inflight_d = inflight_d + 1'b1;

    count_d = count_q + CW'(push_acc) - CW'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q   <= FULL;
      count_q     <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= '0;
      credit_ok_q <= 1'b1;
    end else begin
      credits_q   <= credits_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      credit_ok_q <= (credits_d != '0);
      err_q       <= err_q | {spurious, drop_full, issue_no_credit};
      if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only ever
  // read behind count_q, and resetting a RAM would block memory inference.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) mem_q[wr_ptr_q] <= in_data_i;
  end

  // Empty FIFO presents zero so stale entries never leak downstream.
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign credit_ok_o = credit_ok_q;
  assign count_o     = count_q;
  assign inflight_o  = inflight_q;
  assign err_o       = err_q;

`ifdef SIM
  always_ff @(posedge clk) begin
    if (!rst && err_q == '0)
      assert (int'(credits_q) + int'(count_q) + int'(inflight_q) == DEPTH)
        else $error("delta_collect: credit conservation broken");
  end
`endif

endmodule

// File: tb/tb_delta_collect.sv
// Scoreboard bench for delta_collect: a queue-based model of the delta pipeline
// and FIFO predicts every output beat, counter and sticky error bit.
module tb_delta_collect;

  localparam int DW     = 16;
  localparam int H_TILE = 4;
  localparam int DEPTH  = 16;
  localparam int A_LAT  = 11;
  localparam int W      = DW * H_TILE;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          credit_ok_o, issue_i, in_valid_i, out_valid_o, out_ready_i;
  logic [W-1:0]  in_data_i, out_data_o;
  logic [CW-1:0] count_o, inflight_o;
  logic [2:0]    err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int           t;
    logic [W-1:0] d;
  } beat_t;

  beat_t        pend[$];   // beats travelling through the delta pipeline
  logic [W-1:0] exp_q[$];  // expected FIFO contents, head first
  int           m_cred;
  int           m_infl;
  logic [2:0]   m_err;

  always #5 clk = ~clk;

  delta_collect #(.DW(DW), .H_TILE(H_TILE), .DEPTH(DEPTH), .A_LAT(A_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .credit_ok_o(credit_ok_o),
    .issue_i    (issue_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .count_o    (count_o),
    .inflight_o (inflight_o),
    .err_o      (err_o)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  // Monitor: every accepted output beat must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: unexpected beat 0x%0h, expected none (cycle %0d)", out_data_o, cyc);
      end else begin
        check("out_data", out_data_o, exp_q.pop_front());
      end
    end
  end

  // One clock cycle: compare DUT state with the model, drive inputs, advance model.
  task automatic tick(input bit rs, input bit iss, input bit rdy, input logic [W-1:0] d);
    bit           inv, pop;
    logic [W-1:0] vd;
    beat_t        b;
    check("count_o",     W'(count_o),    W'(exp_q.size()));
    check("out_valid_o", W'(out_valid_o), W'(exp_q.size() != 0));
    check("credit_ok_o", W'(credit_ok_o), W'(m_cred != 0));
    check("inflight_o",  W'(inflight_o), W'(m_infl));
    check("err_o",       W'(err_o),      W'(m_err));

    inv = 1'b0;
    vd  = rnd_data();
    if (pend.size() != 0 && pend[0].t == cyc) begin
      b   = pend.pop_front();
      inv = 1'b1;
      vd  = b.d;
    end
    rst         = rs;
    issue_i     = iss && !rs;
    out_ready_i = rdy;
    in_valid_i  = inv;
    in_data_i   = vd;

    if (rs) begin
      m_cred = DEPTH;
      m_infl = 0;
      m_err  = '0;
      exp_q.delete();
    end else begin
      if (iss) pend.push_back('{cyc + A_LAT, d});
      pop = (exp_q.size() != 0) && rdy;
      if (iss && m_cred == 0) m_err[0] = 1'b1;
      if (inv && m_infl == 0) m_err[2] = 1'b1;
      else if (inv) begin
        if (exp_q.size() < DEPTH || pop) exp_q.push_back(vd);
        else m_err[1] = 1'b1;
      end
      m_cred = (m_cred > 0) ? m_cred - int'(iss) : 0;
      if (pop && m_cred < DEPTH) m_cred++;
      m_infl = m_infl + int'(iss) - int'(inv && m_infl != 0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; issue_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    m_cred = DEPTH; m_infl = 0; m_err = '0;
    @(posedge clk);
    #1;
    cyc++;

    // Reset state
    check("rst credit_ok_o", W'(credit_ok_o), W'(1));
    check("rst out_valid_o", W'(out_valid_o), W'(0));
    check("rst out_data_o",  out_data_o,      W'(0));
    check("rst err_o",       W'(err_o),       W'(0));

    // T1: single beat round trip
    tick(0, 1, 1, W'(16'h3C00));
    repeat (A_LAT) tick(0, 0, 1, '0);
    check("t1 out_valid_o", W'(out_valid_o), W'(1));
    check("t1 out_data_o",  out_data_o,      W'(16'h3C00));
    tick(0, 0, 1, '0);
    tick(0, 0, 1, '0);
    check("t1 credit_ok_o", W'(credit_ok_o), W'(1));
    check("t1 count_o",     W'(count_o),     W'(0));

    // T2: fill all credits with downstream stalled
    tick(1, 0, 0, '0);
    repeat (DEPTH) tick(0, 1, 0, rnd_data());
    check("t2 credit_ok_o", W'(credit_ok_o), W'(0));
    repeat (A_LAT) tick(0, 0, 0, '0);
    check("t2 count_o", W'(count_o), W'(DEPTH));
    check("t2 err_o",   W'(err_o),   W'(0));

    // T3/T4: two issues without credit; first arrives with a pop, second with none
    tick(0, 1, 0, rnd_data());
    tick(0, 1, 0, rnd_data());
    check("t4 err_o issue", W'(err_o), W'(3'b001));
    repeat (A_LAT - 2) tick(0, 0, 0, '0);
    tick(0, 0, 1, '0);
    check("t3 count_o", W'(count_o), W'(DEPTH));
    check("t3 err_o",   W'(err_o),   W'(3'b001));
    tick(0, 0, 0, '0);
    check("t4 count_o", W'(count_o), W'(DEPTH));
    check("t4 err_o",   W'(err_o),   W'(3'b011));

    // T5: reset with beats still in the pipeline
    tick(1, 0, 0, '0);
    repeat (5) tick(0, 1, 1, rnd_data());
    tick(1, 0, 0, '0);
    repeat (A_LAT + 2) tick(0, 0, 1, '0);
    check("t5 err_o",       W'(err_o),       W'(3'b100));
    check("t5 count_o",     W'(count_o),     W'(0));
    check("t5 credit_ok_o", W'(credit_ok_o), W'(1));

    // T6: random stress with a well-behaved issuer and bursty backpressure
    tick(1, 0, 0, '0);
    for (int i = 0; i < 10000; i++) begin
      bit iss, rdy;
      iss = (m_cred != 0) && ($urandom_range(0, 3) != 0);
      rdy = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      tick(0, iss, rdy, rnd_data());
    end
    repeat (A_LAT + DEPTH + 4) tick(0, 0, 1, '0);
    check("t6 err_o",      W'(err_o),        W'(0));
    check("t6 drained",    W'(exp_q.size()), W'(0));
    check("t6 inflight_o", W'(inflight_o),   W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
